// File: rtl/sym_dn_pkg.sv
// -----------------------------------------------------------------------------
// sym_dn_pkg
// Shared constants and types for the symmetric information-bottleneck
// decision-node rank LUT (sym_dn_rank_lut) and its address mapper
// (dn_addr_map).
//   PAGE_W : page address width
//   DEPTH  : entries per bank, 2^(PAGE_W+1)
//   Y0_W   : folded first-message magnitude width
//   Y1_W   : second-message width (LSB selects the bank)
//   idx_t  : word index within a bank, {page, offset}
// -----------------------------------------------------------------------------
package sym_dn_pkg;

  localparam int PAGE_W = 6;
  localparam int DEPTH  = 2 ** (PAGE_W + 1);
  localparam int Y0_W   = 3;
  localparam int Y1_W   = 4;

  typedef logic [PAGE_W:0] idx_t;

endpackage : sym_dn_pkg

// File: rtl/dn_addr_map.sv
// -----------------------------------------------------------------------------
// dn_addr_map
// Combinational mapping of a folded message pair (y0, y1) to a bank select
// and a page address inside that bank.
// Ports:
//   y0   in  [Y0_W-1:0]   folded first message magnitude
//   y1   in  [Y1_W-1:0]   second message (already conditionally inverted)
//   bank out 1            bank select, taken from the LSB of y1
//   page out [PAGE_W-1:0] page address {y0, y1[3:1]}
// -----------------------------------------------------------------------------
module dn_addr_map
  import sym_dn_pkg::*;
(
  input  logic [Y0_W-1:0]   y0,
  input  logic [Y1_W-1:0]   y1,
  output logic              bank,
  output logic [PAGE_W-1:0] page
);

  // The y1 LSB splits the symmetric message space across the two banks, so
  // the remaining bits together with y0 form a dense 64-entry page space.
  assign bank = y1[0];
  assign page = {y0, y1[Y1_W-1:1]};

endmodule : dn_addr_map

// File: rtl/sym_dn_rank_lut.sv
// -----------------------------------------------------------------------------
// sym_dn_rank_lut
// Four-read-port, single-write-port 1-bit decision-node LUT. Each read port
// maps (y0, y1, offset) to a bank/word and returns the stored bit one clock
// later. Two 128x1 banks are written together in one cycle.
// Ports:
//   read_clk              in   single clock for reads and writes
//   rst_n                 in   asynchronous active-low reset; clears memory
//                              and output registers
//   y0_in_k     (k=0..3)  in   [2:0] folded first message magnitude
//   y1_in_k     (k=0..3)  in   [3:0] second message
//   page_addr_offset_k    in   page half select for port k
//   lut_data_k  (k=0..3)  out  registered LUT bit for port k
//   lut_in_bank0/1        in   write data for bank 0 / bank 1
//   page_write_addr       in   [5:0] write page address
//   write_addr_offset     in   write page half select
//   we                    in   write enable (both banks)
// Build option:
//   SYM_DN_RANK_WRITE_BYPASS_EN  when defined, a read of the cell being
//   written in the same cycle returns the incoming write data; otherwise
//   it returns the previously stored value.
// -----------------------------------------------------------------------------
module sym_dn_rank_lut #(
  parameter int PORTS  = 4,
  parameter int PAGE_W = 6,
  parameter int DEPTH  = 128
) (
  input  logic              read_clk,
  input  logic              rst_n,
  input  logic [2:0]        y0_in_0,
  input  logic [2:0]        y0_in_1,
  input  logic [2:0]        y0_in_2,
  input  logic [2:0]        y0_in_3,
  input  logic [3:0]        y1_in_0,
  input  logic [3:0]        y1_in_1,
  input  logic [3:0]        y1_in_2,
  input  logic [3:0]        y1_in_3,
  input  logic              page_addr_offset_0,
  input  logic              page_addr_offset_1,
  input  logic              page_addr_offset_2,
  input  logic              page_addr_offset_3,
  output logic              lut_data_0,
  output logic              lut_data_1,
  output logic              lut_data_2,
  output logic              lut_data_3,
  input  logic              lut_in_bank0,
  input  logic              lut_in_bank1,
  input  logic [PAGE_W-1:0] page_write_addr,
  input  logic              write_addr_offset,
  input  logic              we
);

  import sym_dn_pkg::*;

  logic [Y0_W-1:0]   y0     [PORTS];
  logic [Y1_W-1:0]   y1     [PORTS];
  logic              offset [PORTS];
  logic              bank   [PORTS];
  logic [PAGE_W-1:0] page   [PORTS];
  idx_t              rd_idx [PORTS];
  logic [PORTS-1:0]  rd_bit;
  logic [PORTS-1:0]  lut_q;

  logic [DEPTH-1:0]  bank0_mem;
  logic [DEPTH-1:0]  bank1_mem;
  idx_t              wr_idx;

  assign y0[0] = y0_in_0;
  assign y0[1] = y0_in_1;
  assign y0[2] = y0_in_2;
  assign y0[3] = y0_in_3;
  assign y1[0] = y1_in_0;
  assign y1[1] = y1_in_1;
  assign y1[2] = y1_in_2;
  assign y1[3] = y1_in_3;
  assign offset[0] = page_addr_offset_0;
  assign offset[1] = page_addr_offset_1;
  assign offset[2] = page_addr_offset_2;
  assign offset[3] = page_addr_offset_3;

  assign wr_idx = {page_write_addr, write_addr_offset};

  for (genvar k = 0; k < PORTS; k++) begin : g_port
    dn_addr_map u_map (
      .y0   (y0[k]),
      .y1   (y1[k]),
      .bank (bank[k]),
      .page (page[k])
    );
    assign rd_idx[k] = {page[k], offset[k]};
  end

  // Both banks share one write index; reset clears every cell.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_mem <= '0;
      bank1_mem <= '0;
    end else if (we) begin
      bank0_mem[wr_idx] <= lut_in_bank0;
      bank1_mem[wr_idx] <= lut_in_bank1;
    end
  end

  always_comb begin
    rd_bit = '0;
    for (int k = 0; k < PORTS; k++) begin
      rd_bit[k] = bank[k] ? bank1_mem[rd_idx[k]] : bank0_mem[rd_idx[k]];
`ifdef SYM_DN_RANK_WRITE_BYPASS_EN
      // Forward the write data when this port hits the cell being written.
      if (we && (rd_idx[k] == wr_idx))
        rd_bit[k] = bank[k] ? lut_in_bank1 : lut_in_bank0;
`endif
    end
  end

  // ---- read stage -> output register ----
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) lut_q <= '0;
    else        lut_q <= rd_bit;
  end

  assign lut_data_0 = lut_q[0];
  assign lut_data_1 = lut_q[1];
  assign lut_data_2 = lut_q[2];
  assign lut_data_3 = lut_q[3];

endmodule : sym_dn_rank_lut

// File: tb/tb_sym_dn_rank_lut.sv
// -----------------------------------------------------------------------------
// tb_sym_dn_rank_lut
// Directed self-checking bench for sym_dn_rank_lut. Inputs change on the
// falling edge; outputs are checked on the falling edge after the capturing
// rising edge. A bit-level reference memory tracks every write.
// -----------------------------------------------------------------------------
module tb_sym_dn_rank_lut;

  logic       read_clk;
  logic       rst_n;
  logic [2:0] y0  [4];
  logic [3:0] y1  [4];
  logic       off [4];
  logic       lut [4];
  logic       lut_in_bank0;
  logic       lut_in_bank1;
  logic [5:0] page_write_addr;
  logic       write_addr_offset;
  logic       we;

  logic [127:0] m0;
  logic [127:0] m1;
  int checks;
  int failures;

  sym_dn_rank_lut dut (
    .read_clk           (read_clk),
    .rst_n              (rst_n),
    .y0_in_0            (y0[0]),
    .y0_in_1            (y0[1]),
    .y0_in_2            (y0[2]),
    .y0_in_3            (y0[3]),
    .y1_in_0            (y1[0]),
    .y1_in_1            (y1[1]),
    .y1_in_2            (y1[2]),
    .y1_in_3            (y1[3]),
    .page_addr_offset_0 (off[0]),
    .page_addr_offset_1 (off[1]),
    .page_addr_offset_2 (off[2]),
    .page_addr_offset_3 (off[3]),
    .lut_data_0         (lut[0]),
    .lut_data_1         (lut[1]),
    .lut_data_2         (lut[2]),
    .lut_data_3         (lut[3]),
    .lut_in_bank0       (lut_in_bank0),
    .lut_in_bank1       (lut_in_bank1),
    .page_write_addr    (page_write_addr),
    .write_addr_offset  (write_addr_offset),
    .we                 (we)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference lookup derived from the address map: bank = y1[0],
  // word = {y0, y1[3:1], offset}.
  function automatic logic model_bit(input logic [2:0] a, input logic [3:0] b, input logic o);
    logic [6:0] idx;
    idx = {a, b[3:1], o};
    return b[0] ? m1[idx] : m0[idx];
  endfunction

  // Called on a falling edge; performs one write at the next rising edge.
  task automatic do_write(input logic [5:0] pg, input logic o, input logic b0, input logic b1);
    we = 1'b1; page_write_addr = pg; write_addr_offset = o;
    lut_in_bank0 = b0; lut_in_bank1 = b1;
    @(negedge read_clk);
    we = 1'b0;
    m0[{pg, o}] = b0;
    m1[{pg, o}] = b1;
  endtask

  // Walks ncyc cycles of the 256-address space, four addresses per cycle,
  // checking each port one cycle after it is presented.
  task automatic sweep(input string tag, input int ncyc);
    logic exp_q [4];
    logic [7:0] n;
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < 4; k++) begin
        n = 8'(c * 4 + k);
        off[k] = n[0];
        y1[k]  = n[4:1];
        y0[k]  = n[7:5];
        exp_q[k] = model_bit(y0[k], y1[k], off[k]);
      end
      @(negedge read_clk);
      for (int k = 0; k < 4; k++)
        chk($sformatf("%s_c%0d_p%0d", tag, c, k), 32'(lut[k]), 32'(exp_q[k]));
    end
  endtask

  initial begin
    logic exp_byp;
    checks = 0; failures = 0;
    m0 = '0; m1 = '0;
    rst_n = 1'b0; we = 1'b0;
    lut_in_bank0 = 1'b0; lut_in_bank1 = 1'b0;
    page_write_addr = '0; write_addr_offset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      y0[k] = '0; y1[k] = '0; off[k] = 1'b0;
    end

    // Reset state.
    #12;
    for (int k = 0; k < 4; k++) chk($sformatf("rst_out_p%0d", k), 32'(lut[k]), 32'd0);
    @(negedge read_clk);
    rst_n = 1'b1;

    // Every address reads 0 after reset.
    sweep("post_rst", 64);

    // Single write, page 0x2A offset 1: bank0=1, bank1=0.
    do_write(6'h2A, 1'b1, 1'b1, 1'b0);
    y0[0] = 3'b101; y1[0] = 4'b0100; off[0] = 1'b1;
    y0[1] = 3'b101; y1[1] = 4'b0101; off[1] = 1'b1;
    y0[2] = 3'b000; y1[2] = 4'b0000; off[2] = 1'b0;
    y0[3] = 3'b101; y1[3] = 4'b0100; off[3] = 1'b0;
    @(negedge read_clk);
    chk("wr_p0_bank0", 32'(lut[0]), 32'd1);
    chk("wr_p1_bank1", 32'(lut[1]), 32'd0);
    chk("wr_p2_other", 32'(lut[2]), 32'd0);
    chk("wr_p3_offset0", 32'(lut[3]), 32'd0);

    // All four ports on the same written cell.
    for (int k = 0; k < 4; k++) begin
      y0[k] = 3'b101; y1[k] = 4'b0100; off[k] = 1'b1;
    end
    @(negedge read_clk);
    for (int k = 0; k < 4; k++) chk($sformatf("same_cell_p%0d", k), 32'(lut[k]), 32'd1);

    // Same-cycle write and read of page 0x15 offset 0 bank 0 (currently 0).
`ifdef SYM_DN_RANK_WRITE_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    y0[0] = 3'b010; y1[0] = 4'b1010; off[0] = 1'b0;   // bank 0, page 0x15
    y0[1] = 3'b010; y1[1] = 4'b1011; off[1] = 1'b0;   // bank 1, same word
    do_write(6'h15, 1'b0, 1'b1, 1'b1);
    chk("rw_same_b0", 32'(lut[0]), 32'(exp_byp));
    chk("rw_same_b1", 32'(lut[1]), 32'(exp_byp));
    @(negedge read_clk);
    chk("rw_after_b0", 32'(lut[0]), 32'd1);
    chk("rw_after_b1", 32'(lut[1]), 32'd1);

    // Fill both banks: bank0 = idx[0], bank1 = ~idx[0].
    for (int i = 0; i < 128; i++) begin
      logic [6:0] ix;
      ix = 7'(i);
      do_write(ix[6:1], ix[0], ix[0], ~ix[0]);
    end
    sweep("fill", 64);

    // Reset pulsed mid-sweep.
    sweep("pre_rst", 10);
    y0[0] = 3'b000; y1[0] = 4'b0000; off[0] = 1'b1;   // bank0 idx 1 -> 1
    y0[1] = 3'b000; y1[1] = 4'b0001; off[1] = 1'b0;   // bank1 idx 0 -> 1
    y0[2] = 3'b111; y1[2] = 4'b1110; off[2] = 1'b1;   // bank0 idx 127 -> 1
    y0[3] = 3'b111; y1[3] = 4'b1111; off[3] = 1'b0;   // bank1 idx 126 -> 1
    @(negedge read_clk);
    for (int k = 0; k < 4; k++) chk($sformatf("pre_async_p%0d", k), 32'(lut[k]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("async_rst_p%0d", k), 32'(lut[k]), 32'd0);
    m0 = '0; m1 = '0;
    @(negedge read_clk);
    rst_n = 1'b1;
    sweep("after_rst", 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sym_dn_rank_lut
